// File: rtl/branch_predict_unit.sv
// branch_predict_unit: branch resolution with flag register, 2-bit counter BHT, registered redirect and saturating stats.
// Ports: clk/rst (sync, active-high); flag_we/carry_in/sign_in load ALU flags;
// f_pc -> f_pred_taken is the combinational fetch lookup; ex_* resolve a branch in execute;
// taken/redirect/redirect_pc are registered results; br_count/mispred_count are saturating statistics.
module branch_predict_unit #(
    parameter int ADDR_W     = 32,
    parameter int BHT_DEPTH  = 16,
    parameter int PREDICT_EN = 1,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flag_we,
    input  logic              carry_in,
    input  logic [1:0]        sign_in,
    input  logic [ADDR_W-1:0] f_pc,
    output logic              f_pred_taken,
    input  logic              ex_valid,
    input  logic [2:0]        ex_cond,
    input  logic [ADDR_W-1:0] ex_pc,
    input  logic [ADDR_W-1:0] ex_target,
    input  logic              ex_pred_taken,
    output logic              taken,
    output logic              redirect,
    output logic [ADDR_W-1:0] redirect_pc,
    output logic [CNT_W-1:0]  br_count,
    output logic [CNT_W-1:0]  mispred_count
);
    localparam int IDX_W = $clog2(BHT_DEPTH);
    logic [1:0]        bht_q [BHT_DEPTH];
    logic              carry_q;
    logic [1:0]        sign_q;
    logic              taken_q, redirect_q;
    logic [ADDR_W-1:0] rpc_q, rpc_d;
    logic [CNT_W-1:0]  br_q, br_d, mis_q, mis_d;
    logic              carry_e, res, ev, mis;
    logic [1:0]        sign_e, ctr, ctr_d;
    logic [IDX_W-1:0]  f_idx, ex_idx;
    logic              unused_fpc;
    assign unused_fpc = ^f_pc;
    assign f_idx  = f_pc[IDX_W+1:2];
    assign ex_idx = ex_pc[IDX_W+1:2];
    assign f_pred_taken = (PREDICT_EN != 0) & bht_q[f_idx][1];
    // Flags written this cycle bypass the register so a compare-and-branch pair resolves correctly.
    assign carry_e = flag_we ? carry_in : carry_q;
    assign sign_e  = flag_we ? sign_in : sign_q;
    always_comb begin
        res = 1'b0;
        case (ex_cond)
            3'b001:  res = carry_e;
            3'b010:  res = ~carry_e;
            3'b011:  res = sign_e == 2'b01;
            3'b100:  res = sign_e == 2'b10;
            3'b101:  res = sign_e != 2'b10;
            3'b110:  res = 1'b1;
            3'b111:  res = sign_e == 2'b00;
            default: res = 1'b0;
        endcase
    end
    // The instruction in execute during a redirect cycle is wrong-path and must be ignored.
    assign ev    = ex_valid & (ex_cond != 3'b000) & ~redirect_q;
    assign mis   = ev & (res != ex_pred_taken);
    assign rpc_d = res ? ex_target : ADDR_W'(ex_pc + ADDR_W'(4));
    assign br_d  = (ev & ~&br_q) ? br_q + CNT_W'(1) : br_q;
    assign mis_d = (mis & ~&mis_q) ? mis_q + CNT_W'(1) : mis_q;
    assign ctr   = bht_q[ex_idx];
    assign ctr_d = res ? ((ctr == 2'b11) ? ctr : ctr + 2'd1) : ((ctr == 2'b00) ? ctr : ctr - 2'd1);
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < BHT_DEPTH; i++) bht_q[i] <= 2'b01;
            carry_q    <= 1'b0;
            sign_q     <= 2'b00;
            taken_q    <= 1'b0;
            redirect_q <= 1'b0;
            rpc_q      <= '0;
            br_q       <= '0;
            mis_q      <= '0;
        end else begin
            if (flag_we) begin
                carry_q <= carry_in;
                sign_q  <= sign_in;
            end
            taken_q    <= ev & res;
            redirect_q <= mis;
            if (mis) rpc_q <= rpc_d;
            br_q  <= br_d;
            mis_q <= mis_d;
            if (PREDICT_EN != 0 && ev) bht_q[ex_idx] <= ctr_d;
        end
    end
    assign taken         = taken_q;
    assign redirect      = redirect_q;
    assign redirect_pc   = rpc_q;
    assign br_count      = br_q;
    assign mispred_count = mis_q;
endmodule

// File: tb/tb_branch_predict_unit.sv
// tb_branch_predict_unit: directed scoreboard bench for branch_predict_unit (default and PREDICT_EN=0/CNT_W=4 instances).
module tb_branch_predict_unit;
    typedef struct {
        bit          sel;
        bit          t;
        bit          r;
        logic [31:0] rpc;
        int          br;
        int          mis;
        bit          fp;
    } exp_t;
    logic        clk = 1'b0, rst = 1'b1, flag_we = 1'b0, carry_in = 1'b0, ex_valid = 1'b0, ex_pred_taken = 1'b0;
    logic [1:0]  sign_in = 2'b00;
    logic [2:0]  ex_cond = 3'b000;
    logic [31:0] f_pc = '0, ex_pc = '0, ex_target = '0;
    logic        a_fp, a_t, a_r, b_fp, b_t, b_r;
    logic [31:0] a_rpc, b_rpc;
    logic [15:0] a_br, a_mis;
    logic [3:0]  b_br, b_mis;
    exp_t        q[$];
    int          checks = 0, errors = 0;
    always #5 clk = ~clk;
    branch_predict_unit dut_a (
        .clk(clk), .rst(rst), .flag_we(flag_we), .carry_in(carry_in), .sign_in(sign_in),
        .f_pc(f_pc), .f_pred_taken(a_fp), .ex_valid(ex_valid), .ex_cond(ex_cond), .ex_pc(ex_pc),
        .ex_target(ex_target), .ex_pred_taken(ex_pred_taken), .taken(a_t), .redirect(a_r),
        .redirect_pc(a_rpc), .br_count(a_br), .mispred_count(a_mis)
    );
    branch_predict_unit #(.PREDICT_EN(0), .CNT_W(4)) dut_b (
        .clk(clk), .rst(rst), .flag_we(flag_we), .carry_in(carry_in), .sign_in(sign_in),
        .f_pc(f_pc), .f_pred_taken(b_fp), .ex_valid(ex_valid), .ex_cond(ex_cond), .ex_pc(ex_pc),
        .ex_target(ex_target), .ex_pred_taken(ex_pred_taken), .taken(b_t), .redirect(b_r),
        .redirect_pc(b_rpc), .br_count(b_br), .mispred_count(b_mis)
    );
    task automatic chk(input string n, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%h expected=%h at %0t", n, got, want, $time);
        end
    endtask
    initial forever begin
        exp_t e;
        @(posedge clk);
        #1;
        if (q.size() != 0) begin
            e = q.pop_front();
            chk(e.sel ? "b_taken" : "a_taken", e.sel ? 32'(b_t) : 32'(a_t), 32'(e.t));
            chk(e.sel ? "b_redirect" : "a_redirect", e.sel ? 32'(b_r) : 32'(a_r), 32'(e.r));
            chk(e.sel ? "b_redirect_pc" : "a_redirect_pc", e.sel ? b_rpc : a_rpc, e.rpc);
            chk(e.sel ? "b_br_count" : "a_br_count", e.sel ? 32'(b_br) : 32'(a_br), e.br);
            chk(e.sel ? "b_mispred_count" : "a_mispred_count", e.sel ? 32'(b_mis) : 32'(a_mis), e.mis);
            chk(e.sel ? "b_f_pred_taken" : "a_f_pred_taken", e.sel ? 32'(b_fp) : 32'(a_fp), 32'(e.fp));
        end
    end
    task automatic step(input bit r, input bit fw, input bit c, input logic [1:0] s, input bit v,
                        input logic [2:0] cd, input logic [31:0] pc, input logic [31:0] tg,
                        input bit pr, input logic [31:0] fpc, input exp_t e);
        @(negedge clk);
        rst = r; flag_we = fw; carry_in = c; sign_in = s; ex_valid = v; ex_cond = cd;
        ex_pc = pc; ex_target = tg; ex_pred_taken = pr; f_pc = fpc;
        q.push_back(e);
    endtask
    initial begin
        repeat (2) @(negedge clk);
        step(0,0,0,2'b00,0,3'b000,32'h0,32'h0,0,32'h40,       exp_t'{0,0,0,32'h0,0,0,0});
        step(0,0,0,2'b00,0,3'b000,32'h0,32'h0,0,32'h7C,       exp_t'{0,0,0,32'h0,0,0,0});
        step(0,0,0,2'b00,1,3'b110,32'h40,32'h100,0,32'h40,    exp_t'{0,1,1,32'h100,1,1,1});
        step(0,0,0,2'b00,0,3'b000,32'h0,32'h0,0,32'h80,       exp_t'{0,0,0,32'h100,1,1,1});
        step(0,0,0,2'b00,1,3'b110,32'h40,32'h100,1,32'h40,    exp_t'{0,1,0,32'h100,2,1,1});
        step(0,0,0,2'b00,0,3'b000,32'h0,32'h0,0,32'h40,       exp_t'{0,0,0,32'h100,2,1,1});
        step(0,0,0,2'b00,1,3'b110,32'h40,32'h100,1,32'h40,    exp_t'{0,1,0,32'h100,3,1,1});
        step(0,1,1,2'b01,1,3'b001,32'h40,32'h80,0,32'h40,     exp_t'{0,1,1,32'h80,4,2,1});
        step(0,0,0,2'b00,1,3'b110,32'h44,32'h200,0,32'h44,    exp_t'{0,0,0,32'h80,4,2,0});
        step(0,0,0,2'b00,1,3'b010,32'h44,32'h200,0,32'h44,    exp_t'{0,0,0,32'h80,5,2,0});
        step(0,0,0,2'b00,1,3'b011,32'h44,32'h200,1,32'h44,    exp_t'{0,1,0,32'h80,6,2,0});
        step(0,0,0,2'b00,1,3'b001,32'h44,32'h200,1,32'h44,    exp_t'{0,1,0,32'h80,7,2,1});
        step(0,0,0,2'b00,1,3'b101,32'h48,32'h300,0,32'h48,    exp_t'{0,1,1,32'h300,8,3,1});
        step(0,0,0,2'b00,0,3'b000,32'h0,32'h0,0,32'h48,       exp_t'{0,0,0,32'h300,8,3,1});
        step(0,0,0,2'b00,1,3'b000,32'h48,32'h500,1,32'h48,    exp_t'{0,0,0,32'h300,8,3,1});
        step(0,1,0,2'b00,0,3'b000,32'h0,32'h0,0,32'h48,       exp_t'{0,0,0,32'h300,8,3,1});
        step(0,0,0,2'b00,1,3'b100,32'hFFFFFFFC,32'h10,1,32'hFFFFFFFC, exp_t'{0,0,1,32'h0,9,4,0});
        step(0,0,0,2'b00,0,3'b000,32'h0,32'h0,0,32'hFFFFFFFC, exp_t'{0,0,0,32'h0,9,4,0});
        step(0,0,0,2'b00,1,3'b111,32'h4C,32'h600,1,32'h4C,    exp_t'{0,1,0,32'h0,10,4,1});
        step(0,1,0,2'b10,1,3'b111,32'h4C,32'h600,0,32'h4C,    exp_t'{0,0,0,32'h0,11,4,0});
        step(0,0,0,2'b00,1,3'b100,32'h50,32'h400,0,32'h50,    exp_t'{0,1,1,32'h400,12,5,1});
        step(1,0,0,2'b00,1,3'b110,32'h40,32'h100,0,32'h40,    exp_t'{0,0,0,32'h0,0,0,0});
        step(0,0,0,2'b00,0,3'b000,32'h0,32'h0,0,32'h50,       exp_t'{0,0,0,32'h0,0,0,0});
        step(1,0,0,2'b00,0,3'b000,32'h0,32'h0,0,32'h40,       exp_t'{1,0,0,32'h0,0,0,0});
        for (int i = 1; i <= 21; i++) begin
            step(0,0,0,2'b00,1,3'b110,32'h40,32'h80,0,32'h40, exp_t'{1,1,1,32'h80,(i > 15) ? 15 : i,(i > 15) ? 15 : i,0});
            step(0,0,0,2'b00,0,3'b000,32'h0,32'h0,0,32'h40,   exp_t'{1,0,0,32'h80,(i > 15) ? 15 : i,(i > 15) ? 15 : i,0});
        end
        @(negedge clk);
        ex_valid = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got=%0d expected=0 pending", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/branch_predict_unit.md
# branch_predict_unit

Parametrised branch resolution and prediction unit for the KGP-RISC pipeline. Extends the combinational condition check with registered ALU flags, a direct-mapped table of 2-bit saturating counters, a registered redirect/flush output on mispredict, and saturating branch/mispredict statistics counters. It sits between fetch (prediction lookup) and execute (resolution), and drives the PC-select logic on redirect.

## Interface
- ADDR_W, 32: PC/target width in bits.
- BHT_DEPTH, 16: predictor entries; power of two, at least 2. IDX_W = log2(BHT_DEPTH).
- PREDICT_EN, 1: 1 enables dynamic prediction; 0 forces predict-not-taken and freezes the table.
- CNT_W, 16: width of the statistics counters.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- flag_we  in  1  load carry/sign into the flag register.
- carry_in  in  1  ALU carry.
- sign_in  in  2  ALU sign: 00 positive non-zero, 01 negative, 10 zero; 11 is illegal.
- f_pc  in  ADDR_W  fetch PC used for the lookup.
- f_pred_taken  out  1  combinational prediction for f_pc.
- ex_valid  in  1  branch-slot instruction present in execute.
- ex_cond  in  3  condition code.
- ex_pc  in  ADDR_W  PC of the resolving instruction.
- ex_target  in  ADDR_W  taken target.
- ex_pred_taken  in  1  prediction that was used at fetch.
- taken  out  1  registered resolved direction.
- redirect  out  1  registered one-cycle flush/redirect pulse.
- redirect_pc  out  ADDR_W  registered correct next PC; valid while redirect=1.
- br_count  out  CNT_W  resolved branches.
- mispred_count  out  CNT_W  mispredicts.

## Operation
- Condition codes:
  - 000: not a branch.
  - 001: carry=1.
  - 010: carry=0.
  - 011: sign=01.
  - 100: sign=10.
  - 101: sign!=10.
  - 110: always taken.
  - 111: sign=00 (new code: positive non-zero).
- Effective flags are the flag register. When flag_we=1 in the same cycle as a resolution, carry_in/sign_in bypass the register and are used directly. The flag register loads on flag_we.
- Index is f_pc[IDX_W+1:2] for lookup and ex_pc[IDX_W+1:2] for update. PCs are byte addresses and bits [1:0] are ignored.
- f_pred_taken = PREDICT_EN & counter[index][1]. Fetch applies it only to predecoded branches.
- A resolution event is ex_valid=1, ex_cond!=000, and redirect=0. When redirect=1, ex_valid is ignored because the instruction is wrong-path. Code 000 never updates the table, counts, or redirects.
- On a resolution event:
  - taken ← condition result.
  - Mispredict when result != ex_pred_taken. On mispredict: redirect ← 1, and redirect_pc ← result ? ex_target : ex_pc+4 (modulo 2^ADDR_W).
  - br_count increments; mispred_count increments on mispredict. Both saturate at all-ones.
  - When PREDICT_EN=1, the counter increments on taken and decrements on not-taken, saturating at 11 and 00.
- Without a resolution event: redirect ← 0, taken ← 0, redirect_pc holds.

## Timing
- Reset values:
  - Every counter entry = 01 (weakly not taken).
  - Flags: carry=0, sign=00.
  - taken=0, redirect=0, redirect_pc=0, br_count=0, mispred_count=0.
- rst has priority over every simultaneous update.
- Lookup has zero latency: f_pred_taken is combinational from the table and f_pc.
- Resolution to taken/redirect/redirect_pc/statistics: 1 cycle, visible after the next edge.
- Table update is written at the edge ending the resolution cycle.
- Read-before-write: a same-cycle lookup of the entry being updated returns the old value.
- redirect is exactly one cycle wide. A resolution in the cycle where redirect=1 is dropped: no update, no count, no second redirect.
- Back-to-back resolutions on consecutive cycles are each processed, provided no redirect is pending.
- Reset asserted mid-operation cancels any pending redirect at the same edge.

## Test plan
- Reset, then hold ex_valid=0 for one cycle -> all outputs 0; f_pred_taken=0 for every f_pc.
- flag_we=1, carry_in=1, sign_in=01 with ex_valid=1, ex_cond=001, ex_pred_taken=0, ex_pc=0x40, ex_target=0x80 (bypass case) -> next cycle taken=1, redirect=1, redirect_pc=0x80, br_count=1, mispred_count=1.
- Resolve ex_pc=0x40 with cond 110 on three non-consecutive occasions -> f_pred_taken for f_pc=0x40 goes 0→1 after the first resolution (counter 01→10→11→11). f_pc=0x80 (alias, BHT_DEPTH=16) also reads 1.
- Resolution with ex_pred_taken=1, cond 100, sign=00, ex_pc=0xFFFFFFFC -> redirect=1, redirect_pc=0x00000000 (wrap).
- Mispredict followed by an ex_valid branch in the redirect cycle -> the second branch is ignored: br_count +1 only, redirect low the following cycle.
- PREDICT_EN=0 with 2^CNT_W+5 taken resolutions -> f_pred_taken stays 0, and br_count and mispred_count saturate at all-ones.
